// File: rtl/iso_issue_ctrl_if.sv
// Operand/issue/result bundle between the issue controller and its environment.
// slave is the controller's view; master is the upstream/datapath/downstream view.
interface iso_issue_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             dp_valid;
    logic [WIDTH-1:0] dp_a;
    logic [WIDTH-1:0] dp_b;
    logic [WIDTH-1:0] dp_result;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             idle;

    modport slave (
        input  in_valid, in_a, in_b, dp_result, out_ready,
        output in_ready, dp_valid, dp_a, dp_b, out_valid, out_result, idle
    );

    modport master (
        output in_valid, in_a, in_b, dp_result, out_ready,
        input  in_ready, dp_valid, dp_a, dp_b, out_valid, out_result, idle
    );
endinterface

// File: rtl/iso_issue_ctrl.sv
// Issues one operand pair at a time into an isolated datapath and holds its result.
// Latency: accept -> issue next cycle -> out_valid LATENCY cycles later.
// Backpressure: in_ready low while busy; HOLD accepts a new pair only when out_ready. ISO_ISSUE_ZERO_GATE_EN zeroes dp_a/dp_b outside issue.
module iso_issue_ctrl #(
    parameter int WIDTH       = 32,
    parameter int LATENCY     = 1,
    parameter int IDLE_THRESH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    iso_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_e;

    localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);
    localparam logic [7:0] THRESH    = 8'(IDLE_THRESH);

    state_e           state_q, state_d;
    logic             alive_q;
    logic [3:0]       wcnt_q, wcnt_d;
    logic [WIDTH-1:0] dpa_q, dpa_d, dpb_q, dpb_d, res_q, res_d;
    logic [7:0]       icnt_q, icnt_d;
    logic             idle_q;
    logic             in_rdy, dp_vld, out_vld, capture, accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_ISSUE;
            S_ISSUE: state_d = (LATENCY == 1) ? S_HOLD : S_WAIT;
            S_WAIT:  if (wcnt_q == 4'd1) state_d = S_HOLD;
            S_HOLD:  if (bus.out_ready) state_d = accept ? S_ISSUE : S_IDLE;
        endcase
    end

    // alive_q keeps in_ready low in the cycle reset is released
    always_comb begin
        in_rdy  = 1'b0;
        dp_vld  = 1'b0;
        out_vld = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE:  in_rdy = alive_q;
            S_ISSUE: begin
                dp_vld  = 1'b1;
                capture = (LATENCY == 1);
            end
            S_WAIT:  capture = (wcnt_q == 4'd1);
            S_HOLD:  begin
                out_vld = 1'b1;
                in_rdy  = bus.out_ready;
            end
        endcase
    end

    assign accept = bus.in_valid & in_rdy;

    always_comb begin
        wcnt_d = wcnt_q;
        dpa_d  = dpa_q;
        dpb_d  = dpb_q;
        res_d  = res_q;
        icnt_d = '0;
        if (state_q == S_ISSUE) begin
            wcnt_d = WAIT_LOAD;
        end else if (state_q == S_WAIT) begin
            wcnt_d = wcnt_q - 4'd1;
        end
        if (accept) begin
            dpa_d = bus.in_a;
            dpb_d = bus.in_b;
        end
`ifdef ISO_ISSUE_ZERO_GATE_EN
        else if (state_q == S_ISSUE) begin
            dpa_d = '0;
            dpb_d = '0;
        end
`endif
        if (capture) begin
            res_d = bus.dp_result;
        end
        if (state_q == S_IDLE && !accept) begin
            icnt_d = (icnt_q == THRESH) ? icnt_q : icnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_q <= 1'b0;
            wcnt_q  <= '0;
            dpa_q   <= '0;
            dpb_q   <= '0;
            res_q   <= '0;
            icnt_q  <= '0;
            idle_q  <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            wcnt_q  <= wcnt_d;
            dpa_q   <= dpa_d;
            dpb_q   <= dpb_d;
            res_q   <= res_d;
            icnt_q  <= icnt_d;
            idle_q  <= (icnt_q == THRESH);
        end
    end

    assign bus.in_ready   = in_rdy;
    assign bus.dp_valid   = dp_vld;
    assign bus.dp_a       = dpa_q;
    assign bus.dp_b       = dpb_q;
    assign bus.out_valid  = out_vld;
    assign bus.out_result = res_q;
    assign bus.idle       = idle_q;
endmodule

// File: tb/tb_iso_issue_ctrl.sv
// Drives three controllers (LATENCY 1, 2, 3) with shared stimulus and checks every cycle
// against a transaction-timing model plus a few hand-computed expectations.
module tb_iso_issue_ctrl;
    localparam int W  = 32;
    localparam int TH = 8;
    localparam int N  = 3;
`ifdef ISO_ISSUE_ZERO_GATE_EN
    localparam bit GATED = 1'b1;
`else
    localparam bit GATED = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         mode = 1'b0;

    logic [N-1:0] rdy_w, dpv_w, ov_w, idle_w;
    logic [W-1:0] dpa_w [N];
    logic [W-1:0] dpb_w [N];
    logic [W-1:0] res_w [N];

    always #5 clk = ~clk;

    function automatic logic [W-1:0] dpf(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
        return m ? a * b : a + b;
    endfunction

    for (genvar k = 0; k < N; k++) begin : g
        iso_issue_ctrl_if #(.WIDTH(W)) bus ();
        logic [W-1:0] p0, p1;

        iso_issue_ctrl #(.WIDTH(W), .LATENCY(k + 1), .IDLE_THRESH(TH)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        // datapath: combinational for LATENCY 1, else LATENCY-1 register stages
        always @(posedge clk) begin
            p0 <= dpf(mode, bus.dp_a, bus.dp_b);
            p1 <= p0;
        end
        assign bus.dp_result = (k == 0) ? dpf(mode, bus.dp_a, bus.dp_b) : ((k == 1) ? p0 : p1);
        assign bus.in_valid  = in_valid;
        assign bus.in_a      = in_a;
        assign bus.in_b      = in_b;
        assign bus.out_ready = out_ready;
        assign rdy_w[k]      = bus.in_ready;
        assign dpv_w[k]      = bus.dp_valid;
        assign ov_w[k]       = bus.out_valid;
        assign idle_w[k]     = bus.idle;
        assign dpa_w[k]      = bus.dp_a;
        assign dpb_w[k]      = bus.dp_b;
        assign res_w[k]      = bus.out_result;
    end

    // model state: one in-flight op per DUT described by its issue and hold cycles
    int           nchk = 0;
    int           nerr = 0;
    int           cyc  = 0;
    bit           alive;
    bit           busy    [N];
    bit           acc_m   [N];
    int           issue_c [N];
    int           hold_c  [N];
    int           r1      [N];
    int           r2      [N];
    logic [W-1:0] opa [N];
    logic [W-1:0] opb [N];
    logic [W-1:0] eres [N];
    logic [W-1:0] last_a [N];
    logic [W-1:0] last_b [N];
    logic [W-1:0] last_res [N];

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        alive = 1'b0;
        for (int k = 0; k < N; k++) begin
            busy[k] = 1'b0; acc_m[k] = 1'b0;
            r1[k] = 0; r2[k] = 0;
            last_a[k] = '0; last_b[k] = '0; last_res[k] = '0;
        end
    endtask

    task automatic compare_cycle();
        for (int k = 0; k < N; k++) begin
            bit hold, e_rdy, e_dpv, idlecyc;
            logic [W-1:0] e_a, e_b;
            hold  = busy[k] && cyc >= hold_c[k];
            e_rdy = alive && (!busy[k] || (hold && out_ready));
            e_dpv = busy[k] && cyc == issue_c[k];
            e_a   = e_dpv ? opa[k] : (GATED ? '0 : last_a[k]);
            e_b   = e_dpv ? opb[k] : (GATED ? '0 : last_b[k]);
            check($sformatf("in_ready[%0d]", k),   rdy_w[k],  e_rdy);
            check($sformatf("dp_valid[%0d]", k),   dpv_w[k],  e_dpv);
            check($sformatf("dp_a[%0d]", k),       dpa_w[k],  e_a);
            check($sformatf("dp_b[%0d]", k),       dpb_w[k],  e_b);
            check($sformatf("out_valid[%0d]", k),  ov_w[k],   hold);
            check($sformatf("out_result[%0d]", k), res_w[k],  last_res[k]);
            check($sformatf("idle[%0d]", k),       idle_w[k], r2[k] >= TH);
            if (rst_n) begin
                acc_m[k] = in_valid && e_rdy;
                idlecyc  = !busy[k] && !acc_m[k];
                if (e_dpv) begin
                    last_a[k] = opa[k];
                    last_b[k] = opb[k];
                end
                if (busy[k] && cyc + 1 == hold_c[k]) last_res[k] = eres[k];
                if (hold && out_ready) busy[k] = 1'b0;
                r2[k] = r1[k];
                r1[k] = idlecyc ? ((r1[k] < 1000) ? r1[k] + 1 : r1[k]) : 0;
                if (acc_m[k]) begin
                    busy[k]    = 1'b1;
                    issue_c[k] = cyc + 1;
                    hold_c[k]  = cyc + 1 + (k + 1);
                    opa[k]     = in_a;
                    opb[k]     = in_b;
                    eres[k]    = dpf(mode, in_a, in_b);
                end
            end
        end
        if (rst_n) begin
            cyc++;
            alive = 1'b1;
        end
    endtask

    task automatic step(input bit r, input bit iv, input logic [W-1:0] a, input logic [W-1:0] b, input bit ordy);
        @(posedge clk);
        #1;
        rst_n = r; in_valid = iv; in_a = a; in_b = b; out_ready = ordy;
        @(negedge clk);
        if (!rst_n) model_reset();
        compare_cycle();
    endtask

    int           cnt;
    int           j;
    int           tq [$];
    logic [W-1:0] rq [$];

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        repeat (3) step(0, 0, 0, 0, 1);

        // reset release then stall: cycle 0 is the release cycle
        step(1, 0, 0, 0, 1);
        for (int i = 1; i <= 12; i++) begin
            step(1, 0, 0, 0, 1);
            if (i == 1) check("stall_in_ready_c1", rdy_w[0], 1);
            if (i == 8) check("stall_idle_c8", idle_w[0], 0);
            if (i == 9) check("stall_idle_c9", idle_w[0], 1);
        end

        // single add op
        mode = 1'b0;
        step(1, 1, 5, 7, 1);
        step(1, 0, 0, 0, 1);
        check("add_dp_valid", dpv_w[0], 1);
        check("add_dp_a", dpa_w[0], 5);
        check("add_dp_b", dpb_w[0], 7);
        step(1, 0, 0, 0, 1);
        check("add_out_valid", ov_w[0], 1);
        check("add_out_result", res_w[0], 12);
        check("add_idle_clear", idle_w[0], 0);
        step(1, 0, 0, 0, 1);
        check("add_out_valid_1cyc", ov_w[0], 0);
        repeat (4) step(1, 0, 0, 0, 1);

        // multiplier on the LATENCY=3 instance
        mode = 1'b1;
        step(1, 1, 3, 4, 1);
        step(1, 0, 0, 0, 1);
        check("mul_dp_valid", dpv_w[2], 1);
        step(1, 0, 0, 0, 1);
        check("mul_dp_a_wait", dpa_w[2], GATED ? 0 : 3);
        step(1, 0, 0, 0, 1);
        check("mul_out_valid_early", ov_w[2], 0);
        step(1, 0, 0, 0, 1);
        check("mul_out_valid", ov_w[2], 1);
        check("mul_out_result", res_w[2], 12);
        repeat (4) step(1, 0, 0, 0, 1);

        // output backpressure with a new pair waiting
        step(1, 1, 9, 10, 0);
        cnt = 0;
        for (int i = 1; i <= 14; i++) begin
            step(1, 1, 11, 12, 0);
            if (i >= 2 && dpv_w[0]) cnt++;
        end
        check("bp_out_result", res_w[0], 90);
        check("bp_in_ready", rdy_w[0], 0);
        check("bp_out_valid", ov_w[0], 1);
        check("bp_no_reissue", cnt, 0);
        step(1, 1, 11, 12, 1);
        check("bp_release_ready", rdy_w[0], 1);
        step(1, 0, 0, 0, 1);
        check("bp_reissue", dpv_w[0], 1);
        check("bp_reissue_a", dpa_w[0], 11);
        repeat (8) step(1, 0, 0, 0, 1);

        // back-to-back stream on the LATENCY=2 instance
        mode = 1'b0;
        j = 0;
        for (int i = 0; i < 30; i++) begin
            step(1, j < 4, j + 1, j + 1, 1);
            if (ov_w[1]) begin
                rq.push_back(res_w[1]);
                tq.push_back(cyc);
            end
            if (acc_m[1]) j++;
        end
        check("b2b_count", rq.size(), 4);
        for (int i = 0; i < rq.size() && i < 4; i++) begin
            check($sformatf("b2b_result%0d", i), rq[i], 2 * (i + 1));
            if (i > 0) check($sformatf("b2b_spacing%0d", i), tq[i] - tq[i-1], 3);
        end

        // reset in the middle of an operation
        step(1, 1, 6, 6, 1);
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("rst_out_result", res_w[1], 0);
        check("rst_dp_a", dpa_w[2], 0);
        check("rst_in_ready", rdy_w[0], 0);
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, 0, 1);
            if (ov_w != '0) cnt++;
        end
        check("rst_no_stale_out", cnt, 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(1, $urandom_range(0, 9) < 6, W'($urandom_range(0, 1000)),
                 W'($urandom_range(0, 1000)), $urandom_range(0, 9) < 7);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/iso_issue_ctrl.md
# iso_issue_ctrl

Producer-side controller for operand-isolated arithmetic datapaths. It accepts operand pairs over a valid/ready handshake and launches each pair into a downstream isolated datapath (adder, multiplier) as a single-cycle qualified issue. It captures the result after a fixed datapath latency and presents it on a held valid/ready output. It also flags a sustained-idle condition for upstream power control.

## Interface
- WIDTH, 32, operand and result width in bits.
- LATENCY, 1, datapath latency in cycles, legal range 1..15. A value of 1 means a combinational datapath.
- IDLE_THRESH, 8, number of consecutive idle cycles before `idle` asserts, legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream operand pair valid.
- in_ready  output  1  controller can accept an operand pair.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- dp_valid  output  1  issue qualifier to the datapath; high for exactly one cycle per operation.
- dp_a  output  WIDTH  isolated operand A to the datapath.
- dp_b  output  WIDTH  isolated operand B to the datapath.
- dp_result  input  WIDTH  result returned by the datapath.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_result  output  WIDTH  captured result.
- idle  output  1  no issue and no operation in flight for at least IDLE_THRESH cycles.

## Operation
- FSM states: IDLE, ISSUE, WAIT, HOLD. Exactly one operation is in flight at a time.
- IDLE:
  - in_ready=1.
  - If in_valid, register in_a/in_b and go to ISSUE.
- ISSUE (1 cycle):
  - dp_valid=1, dp_a/dp_b drive the registered operands.
  - If LATENCY=1, capture dp_result at the end of this cycle and go to HOLD.
  - Otherwise load the wait counter with LATENCY-1 and go to WAIT.
- WAIT:
  - dp_valid=0; the counter decrements each cycle.
  - When the counter reads 1, capture dp_result at the end of that cycle and go to HOLD.
- HOLD:
  - out_valid=1; out_result is stable until the handshake.
  - On out_ready, leave HOLD.
  - in_ready=out_ready in HOLD, which gives back-to-back acceptance. If in_valid and out_ready are both high, accept the new pair and go straight to ISSUE. If only out_ready is high, go to IDLE.
- dp_a/dp_b are registered outputs, so they never glitch. They change only on the edges that enter or leave ISSUE.
- Idle counter:
  - Increments each cycle the FSM is in IDLE without an acceptance, saturating at IDLE_THRESH.
  - Clears to 0 on any acceptance and in every non-IDLE state.
  - idle = (count == IDLE_THRESH), registered.
- No arithmetic is performed in the block; widths pass through unchanged.

## Timing
- Reset values:
  - in_ready=0 during reset; it becomes 1 in the first cycle after reset release.
  - dp_valid=0, dp_a=0, dp_b=0, out_valid=0, out_result=0, idle=0, FSM=IDLE, idle count=0.
- Latency: acceptance at edge E gives dp_valid in cycle E+1, and out_valid first high in cycle E+1+LATENCY.
- Throughput: with continuous in_valid and out_ready, one result per LATENCY+1 cycles.
- out_result, and out_valid once set, do not change while out_ready=0.
- Reset asserted mid-operation aborts immediately. All outputs return to reset values and the in-flight result is discarded.
- in_valid during ISSUE/WAIT is ignored (in_ready=0); upstream holds its data.

## Configuration
- ISO_ISSUE_ZERO_GATE_EN defined: dp_a/dp_b are forced to 0 in every cycle where dp_valid=0.
- ISO_ISSUE_ZERO_GATE_EN undefined: dp_a/dp_b hold the last issued operands when dp_valid=0, and are 0 only after reset before the first issue. Either way the datapath inputs do not toggle while not issued.

## Test plan
- Reset then stall: release rst_n with in_valid=0, LATENCY=1, IDLE_THRESH=8 -> in_ready=1 from cycle 1, idle=0 through cycle 8, idle=1 from cycle 9 onward.
- Single op, LATENCY=1: accept a=5, b=7 with the datapath an adder, out_ready=1 -> dp_valid high 1 cycle with dp_a=5, dp_b=7; out_valid for 1 cycle with out_result=12 two cycles after acceptance; idle cleared.
- LATENCY=3 multiplier: a=3, b=4 -> dp_valid 1 cycle, out_result=12 with out_valid 4 cycles after acceptance; with ZERO_GATE_EN, dp_a/dp_b=0 in the 2 WAIT cycles.
- Output backpressure: out_ready=0 for 10 cycles during HOLD, in_valid=1 with a new pair -> out_result stable, in_ready=0, no second dp_valid; when out_ready=1, new pair accepted in the same cycle and the next cycle is ISSUE.
- Back-to-back stream: 4 pairs (1,1),(2,2),(3,3),(4,4), LATENCY=2, out_ready=1 -> results 2,4,6,8 in order, one every 3 cycles.
- Mid-operation reset: assert rst_n=0 during WAIT -> all outputs 0 immediately; after release there is no out_valid for the aborted op.
